// File: rtl/depth_map_write_if.sv
// Pixel-stream and frame-buffer write bundle for depth_map_write.
// The stream source and the RAM/status observer sit on the master side; the packer sits on the slave side.
interface depth_map_write_if #(
    parameter int ADDR_W = 15
);
    logic              VSYNC;
    logic              HSYNC;
    logic [7:0]        DATA_0;
    logic [7:0]        DATA_1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              frame_done;
    logic              err_abort;
    logic [7:0]        frame_cnt;

    modport master (
        output VSYNC, HSYNC, DATA_0, DATA_1,
        input  wr_en, wr_addr, wr_data, busy, frame_done, err_abort, frame_cnt
    );

    modport slave (
        input  VSYNC, HSYNC, DATA_0, DATA_1,
        output wr_en, wr_addr, wr_data, busy, frame_done, err_abort, frame_cnt
    );
endinterface

// File: rtl/depth_map_write.sv
// Packs two-pixel beats into 32-bit frame-buffer words, with optional bottom-up row order.
// Tracks frame framing from VSYNC and reports completion or truncation of each frame.
module depth_map_write #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int FLIP_V = 0,
    parameter int ADDR_W = 15
) (
    input  logic              HCLK,
    input  logic              HRESET,
    depth_map_write_if.slave  px
);
    localparam logic [ADDR_W-1:0] LAST_ROW      = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(WIDTH - 2);
    localparam logic [ADDR_W-1:0] WORDS_PER_ROW = ADDR_W'(WIDTH / 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] row_reg;
    logic [ADDR_W-1:0] col_reg;
    logic              phase_reg;
    logic [15:0]       low_half_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [31:0]       wr_data_reg;
    logic              busy_reg;
    logic              frame_done_reg;
    logic              err_abort_reg;
    logic [7:0]        frame_cnt_reg;

    logic              accept;
    logic              abort;
    logic              clear_pos;
    logic              write_go;
    logic              last_word;
    logic [ADDR_W-1:0] store_row;
    logic [ADDR_W-1:0] word_addr;

    // col_reg/row_reg point at the beat being accepted; on a phase-1 beat col_reg>>2 is px0's word.
    assign last_word = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
    assign write_go  = accept && phase_reg;

    generate
        if (FLIP_V != 0) begin : g_flip
            assign store_row = LAST_ROW - row_reg;
        end else begin : g_noflip
            assign store_row = row_reg;
        end
    endgenerate

    assign word_addr = store_row * WORDS_PER_ROW + (col_reg >> 2);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        abort      = 1'b0;
        clear_pos  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (px.VSYNC) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                clear_pos = 1'b1;
                if (!px.VSYNC) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A new VSYNC truncates the frame and takes priority over any beat this cycle.
                if (px.VSYNC) begin
                    abort      = 1'b1;
                    state_next = ST_ARMED;
                end else if (px.HSYNC) begin
                    accept = 1'b1;
                    if (phase_reg && last_word) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            row_reg        <= '0;
            col_reg        <= '0;
            phase_reg      <= 1'b0;
            low_half_reg   <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            err_abort_reg  <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            wr_en_reg      <= write_go;
            frame_done_reg <= write_go && last_word;
            err_abort_reg  <= abort;
            busy_reg       <= (state_next != ST_IDLE);
            if (write_go) begin
                wr_addr_reg <= word_addr;
                wr_data_reg <= {px.DATA_1, px.DATA_0, low_half_reg};
            end
            if (write_go && last_word) frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if (clear_pos) begin
                row_reg   <= '0;
                col_reg   <= '0;
                phase_reg <= 1'b0;
            end else if (accept) begin
                phase_reg <= ~phase_reg;
                if (!phase_reg) low_half_reg <= {px.DATA_1, px.DATA_0};
                if (col_reg == LAST_COL) begin
                    col_reg <= '0;
                    row_reg <= row_reg + ADDR_W'(1);
                end else begin
                    col_reg <= col_reg + ADDR_W'(2);
                end
            end
        end
    end

    assign px.wr_en      = wr_en_reg;
    assign px.wr_addr    = wr_addr_reg;
    assign px.wr_data    = wr_data_reg;
    assign px.busy       = busy_reg;
    assign px.frame_done = frame_done_reg;
    assign px.err_abort  = err_abort_reg;
    assign px.frame_cnt  = frame_cnt_reg;
endmodule
